// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin sharing of one aes_core between two block requesters
// Optional key cache (skip redundant key expansion): define AES_ARB_KEY_CACHE_EN
module aes_core_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_encdec,
    input  logic [255:0] req0_key,
    input  logic [1:0]   req0_keylen,
    input  logic [127:0] req0_block,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_encdec,
    input  logic [255:0] req1_key,
    input  logic [1:0]   req1_keylen,
    input  logic [127:0] req1_block,
    output logic         resp0_valid,
    output logic [127:0] resp0_result,
    output logic         resp1_valid,
    output logic [127:0] resp1_result,
    output logic         resp_err,
    output logic         core_encdec,
    output logic         core_init,
    output logic         core_next,
    output logic [255:0] core_key,
    output logic [1:0]   core_keylen,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result,
    input  logic         core_result_valid
);

    localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_INIT_WAIT,
        S_NEXT,
        S_NEXT_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    logic           r_rr_ptr;
    logic           r_gnt;
    logic [9:0]     r_cnt;
    logic           r_core_encdec;
    logic           r_core_init;
    logic           r_core_next;
    logic [255:0]   r_core_key;
    logic [1:0]     r_core_keylen;
    logic [127:0]   r_core_block;
    logic           r_resp0_valid;
    logic           r_resp1_valid;
    logic           r_resp_err;
    logic [127:0]   r_result;
`ifdef AES_ARB_KEY_CACHE_EN
    logic           r_key_valid;
    logic [255:0]   r_loaded_key;
    logic [1:0]     r_loaded_keylen;
`endif

    logic           w_grant;
    logic           w_sel;
    logic           w_sel_encdec;
    logic [255:0]   w_sel_key;
    logic [1:0]     w_sel_keylen;
    logic [127:0]   w_sel_block;
    logic           w_need_init;
    logic           w_timeout;

    // Accept is combinational so the requester sees ready in the same cycle its fields are captured.
    // Gated by reset_n so nothing is accepted while reset is asserted.
    assign w_grant      = reset_n && (r_state == S_IDLE) && core_ready && (req0_valid || req1_valid);
    assign w_sel        = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
    assign w_sel_encdec = w_sel ? req1_encdec : req0_encdec;
    assign w_sel_key    = w_sel ? req1_key    : req0_key;
    assign w_sel_keylen = w_sel ? req1_keylen : req0_keylen;
    assign w_sel_block  = w_sel ? req1_block  : req0_block;
    assign w_timeout    = (r_cnt == C_TIMEOUT);

`ifdef AES_ARB_KEY_CACHE_EN
    // Encdec is deliberately not compared: the core's expanded key serves both directions.
    assign w_need_init  = !r_key_valid || (w_sel_key != r_loaded_key) || (w_sel_keylen != r_loaded_keylen);
`else
    assign w_need_init  = 1'b1;
`endif

    assign req0_ready   = w_grant && !w_sel;
    assign req1_ready   = w_grant &&  w_sel;
    assign resp0_valid  = r_resp0_valid;
    assign resp1_valid  = r_resp1_valid;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp_err     = r_resp_err;
    assign core_encdec  = r_core_encdec;
    assign core_init    = r_core_init;
    assign core_next    = r_core_next;
    assign core_key     = r_core_key;
    assign core_keylen  = r_core_keylen;
    assign core_block   = r_core_block;

    // Transaction sequencer: grant, optional key expansion, block op, response; pulses default low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= 1'b0;
            r_gnt           <= 1'b0;
            r_cnt           <= '0;
            r_core_encdec   <= 1'b0;
            r_core_init     <= 1'b0;
            r_core_next     <= 1'b0;
            r_core_key      <= '0;
            r_core_keylen   <= '0;
            r_core_block    <= '0;
            r_resp0_valid   <= 1'b0;
            r_resp1_valid   <= 1'b0;
            r_resp_err      <= 1'b0;
            r_result        <= '0;
`ifdef AES_ARB_KEY_CACHE_EN
            r_key_valid     <= 1'b0;
            r_loaded_key    <= '0;
            r_loaded_keylen <= '0;
`endif
        end else begin
            r_core_init   <= 1'b0;
            r_core_next   <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt         <= w_sel;
                        r_rr_ptr      <= ~w_sel;
                        r_core_encdec <= w_sel_encdec;
                        r_core_key    <= w_sel_key;
                        r_core_keylen <= w_sel_keylen;
                        r_core_block  <= w_sel_block;
                        if (w_need_init) begin
                            r_core_init <= 1'b1;
                            r_state     <= S_INIT;
                        end else begin
                            r_core_next <= 1'b1;
                            r_state     <= S_NEXT;
                        end
                    end
                end
                S_INIT: begin
`ifdef AES_ARB_KEY_CACHE_EN
                    r_key_valid <= 1'b0;
`endif
                    r_cnt   <= '0;
                    r_state <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    // r_cnt == 0 marks the first wait cycle, where the core still shows stale ready
                    if ((r_cnt != 0) && core_ready) begin
`ifdef AES_ARB_KEY_CACHE_EN
                        r_key_valid     <= 1'b1;
                        r_loaded_key    <= r_core_key;
                        r_loaded_keylen <= r_core_keylen;
`endif
                        r_core_next <= 1'b1;
                        r_state     <= S_NEXT;
                    end else if (w_timeout) begin
                        r_result      <= '0;
                        r_resp_err    <= 1'b1;
                        r_resp0_valid <= ~r_gnt;
                        r_resp1_valid <= r_gnt;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_NEXT: begin
                    r_cnt   <= '0;
                    r_state <= S_NEXT_WAIT;
                end
                S_NEXT_WAIT: begin
                    if ((r_cnt != 0) && core_ready && core_result_valid) begin
                        r_result      <= core_result;
                        r_resp0_valid <= ~r_gnt;
                        r_resp1_valid <= r_gnt;
                        r_state       <= S_RESP;
                    end else if (w_timeout) begin
`ifdef AES_ARB_KEY_CACHE_EN
                        r_key_valid   <= 1'b0;
`endif
                        r_result      <= '0;
                        r_resp_err    <= 1'b1;
                        r_resp0_valid <= ~r_gnt;
                        r_resp1_valid <= r_gnt;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - directed self-checking bench for aes_core_arbiter
module tb_aes_core_arbiter;

    localparam int TO  = 16;
    localparam int LAT = 5;
`ifdef AES_ARB_KEY_CACHE_EN
    localparam int CI = 0;
`else
    localparam int CI = 1;
`endif

    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [1:0]   KL128 = 2'b00;
    localparam logic [1:0]   KL256 = 2'b10;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] BAD   = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         req0_valid = 1'b0, req0_ready, req0_encdec = 1'b0;
    logic [255:0] req0_key = '0;
    logic [1:0]   req0_keylen = '0;
    logic [127:0] req0_block = '0;
    logic         req1_valid = 1'b0, req1_ready, req1_encdec = 1'b0;
    logic [255:0] req1_key = '0;
    logic [1:0]   req1_keylen = '0;
    logic [127:0] req1_block = '0;
    logic         resp0_valid, resp1_valid, resp_err;
    logic [127:0] resp0_result, resp1_result;
    logic         core_encdec, core_init, core_next;
    logic [255:0] core_key;
    logic [1:0]   core_keylen;
    logic [127:0] core_block;
    logic         core_ready = 1'b1;
    logic [127:0] core_result = '0;
    logic         core_result_valid = 1'b0;

    aes_core_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_encdec(req0_encdec),
        .req0_key(req0_key), .req0_keylen(req0_keylen), .req0_block(req0_block),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_encdec(req1_encdec),
        .req1_key(req1_key), .req1_keylen(req1_keylen), .req1_block(req1_block),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp_err(resp_err),
        .core_encdec(core_encdec), .core_init(core_init), .core_next(core_next),
        .core_key(core_key), .core_keylen(core_keylen), .core_block(core_block),
        .core_ready(core_ready), .core_result(core_result), .core_result_valid(core_result_valid)
    );

    // Known-answer lookup standing in for the AES datapath
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [1:0] kl,
                                             input logic e, input logic [127:0] b);
        if (kl == KL128 && k == K128 &&  e && b == PT)    return CT128;
        if (kl == KL128 && k == K128 && !e && b == CT128) return PT;
        if (kl == KL256 && k == K256 &&  e && b == PT)    return CT256;
        if (kl == KL256 && k == K256 && !e && b == CT256) return PT;
        return BAD;
    endfunction

    // Behavioural aes_core: ready lags one cycle, result uses the key loaded by the last init
    logic [255:0] m_key = '0;
    logic [1:0]   m_kl = '0;
    logic [127:0] m_blk = '0;
    logic         m_enc = 1'b0, m_pend = 1'b0, m_is_next = 1'b0, m_stall = 1'b0;
    logic         stall_next = 1'b0;
    int           m_cnt = 0;
    always @(posedge clk) begin
        core_ready <= !m_pend && (m_cnt == 0) && !m_stall;
        if (!stall_next) m_stall <= 1'b0;
        if (core_init) begin
            m_key <= core_key; m_kl <= core_keylen; m_pend <= 1'b1; m_is_next <= 1'b0;
        end else if (core_next) begin
            m_blk <= core_block; m_enc <= core_encdec; m_pend <= 1'b1; m_is_next <= 1'b1;
            core_result_valid <= 1'b0;
            if (stall_next) m_stall <= 1'b1;
        end else if (m_pend) begin
            m_pend <= 1'b0; m_cnt <= LAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && m_is_next) begin
                core_result <= aes_ref(m_key, m_kl, m_enc, m_blk);
                core_result_valid <= 1'b1;
            end
        end
    end

    // Output monitor
    int init_cnt = 0, next_cnt = 0, r0_cnt = 0, r1_cnt = 0;
    logic [127:0] r0_res = '0, r1_res = '0;
    logic r0_err = 1'b0, r1_err = 1'b0;
    always @(negedge clk) begin
        if (core_init === 1'b1) init_cnt <= init_cnt + 1;
        if (core_next === 1'b1) next_cnt <= next_cnt + 1;
        if (resp0_valid === 1'b1) begin r0_cnt <= r0_cnt + 1; r0_res <= resp0_result; r0_err <= resp_err; end
        if (resp1_valid === 1'b1) begin r1_cnt <= r1_cnt + 1; r1_res <= resp1_result; r1_err <= resp_err; end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic e, input logic [255:0] k,
                         input logic [1:0] kl, input logic [127:0] b);
        if (ch == 0) begin req0_valid = v; req0_encdec = e; req0_key = k; req0_keylen = kl; req0_block = b; end
        else         begin req1_valid = v; req1_encdec = e; req1_key = k; req1_keylen = kl; req1_block = b; end
    endtask

    task automatic wait_resp(input int ch, input int base, output bit seen);
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk); #2;
            seen = (ch == 0) ? (r0_cnt != base) : (r1_cnt != base);
        end
    endtask

    task automatic run_txn(input string tag, input int ch, input logic e, input logic [255:0] k,
                           input logic [1:0] kl, input logic [127:0] b, input logic [127:0] exp_res,
                           input logic exp_err, input int exp_inits);
        int i0, c0, c1;
        bit acc, seen;
        @(negedge clk); #2;
        i0 = init_cnt; c0 = r0_cnt; c1 = r1_cnt;
        drive(ch, 1'b1, e, k, kl, b);
        acc = 0;
        for (int c = 0; c < 100 && !acc; c++) begin
            #1;
            if ((ch == 0 ? req0_ready : req1_ready) === 1'b1) acc = 1;
            else @(negedge clk);
        end
        if (acc) begin @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; end
        chk({tag, " accept"}, 256'(acc), 256'd1);
        wait_resp(ch, ch == 0 ? c0 : c1, seen);
        chk({tag, " resp seen"}, 256'(seen), 256'd1);
        chk({tag, " result"}, 256'(ch == 0 ? r0_res : r1_res), 256'(exp_res));
        chk({tag, " err"}, 256'(ch == 0 ? r0_err : r1_err), 256'(exp_err));
        chk({tag, " inits"}, 256'(init_cnt - i0), 256'(exp_inits));
        chk({tag, " other ch quiet"}, 256'(ch == 0 ? r1_cnt - c1 : r0_cnt - c0), 256'd0);
    endtask

    typedef struct {
        int           ch;
        logic         enc;
        logic [255:0] key;
        logic [1:0]   kl;
        logic [127:0] blk;
        logic [127:0] res;
        int           inits;
    } vec_t;

    vec_t vecs[7];
    int   order[$];
    int   i0, c0, c1, n0, first;
    bit   seen, acc;

    initial begin
        vecs[0] = '{0, 1'b1, K128, KL128, PT,    CT128, 1};
        vecs[1] = '{0, 1'b0, K128, KL128, CT128, PT,    CI};
        vecs[2] = '{1, 1'b1, K256, KL256, PT,    CT256, 1};
        vecs[3] = '{1, 1'b0, K256, KL256, CT256, PT,    CI};
        vecs[4] = '{0, 1'b1, K256, KL256, PT,    CT256, CI};
        vecs[5] = '{1, 1'b1, K128, KL256, PT,    BAD,   1};
        vecs[6] = '{1, 1'b1, K128, KL128, PT,    CT128, 1};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset ctl", {248'b0, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err,
                          core_init, core_next, core_encdec}, 256'd0);
        chk("reset core_key", core_key, 256'd0);
        chk("reset core_block/keylen", {126'b0, core_keylen, core_block}, 256'd0);
        chk("reset result", {resp0_result, resp1_result}, 256'd0);

        // Simultaneous requests out of reset, held for continuous load
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1'b1, 1'b1, K128, KL128, PT);
        drive(1, 1'b1, 1'b1, K256, KL256, PT);
        for (int c = 0; c < 400 && order.size() < 4; c++) begin
            #1;
            if (req0_ready === 1'b1) order.push_back(0);
            if (req1_ready === 1'b1) order.push_back(1);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 300 && !(r0_cnt == 2 && r1_cnt == 2); c++) @(negedge clk);
        #2;
        chk("rr grant count", 256'(order.size()), 256'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr grant %0d", i), 256'(order.size() > i ? order[i] : -1), 256'(i % 2));
        chk("rr resp counts", {224'b0, 16'(r0_cnt), 16'(r1_cnt)}, {224'b0, 16'd2, 16'd2});
        chk("rr ch0 result", 256'(r0_res), 256'(CT128));
        chk("rr ch1 result", 256'(r1_res), 256'(CT256));
        chk("rr inits", 256'(init_cnt), 256'd4);

        // Table of single-channel transactions
        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].enc, vecs[i].key, vecs[i].kl,
                    vecs[i].blk, vecs[i].res, 1'b0, vecs[i].inits);

        // Core never returns ready after next: timeout error, then forced re-init
        stall_next = 1'b1;
        run_txn("timeout", 0, 1'b1, K128, KL128, PT, 128'h0, 1'b1, CI);
        stall_next = 1'b0;
        run_txn("post-timeout", 0, 1'b1, K128, KL128, PT, CT128, 1'b0, 1);

        // Reset during NEXT_WAIT
        @(negedge clk); #2;
        c0 = r0_cnt; c1 = r1_cnt; n0 = next_cnt;
        drive(0, 1'b1, 1'b1, K128, KL128, PT);
        acc = 0;
        for (int c = 0; c < 100 && !acc; c++) begin
            #1;
            if (req0_ready === 1'b1) acc = 1;
            else @(negedge clk);
        end
        @(posedge clk); #1; req0_valid = 1'b0;
        chk("abort accept", 256'(acc), 256'd1);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #2;
            seen = (next_cnt != n0);
        end
        chk("abort next seen", 256'(seen), 256'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #1;
        chk("abort ctl zero", {250'b0, resp0_valid, resp1_valid, resp_err, core_init, core_next, core_encdec}, 256'd0);
        chk("abort core_key zero", core_key, 256'd0);
        chk("abort core_block zero", 256'(core_block), 256'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("abort no resp", {224'b0, 16'(r0_cnt - c0), 16'(r1_cnt - c1)}, 256'd0);
        i0 = init_cnt;
        drive(0, 1'b1, 1'b1, K128, KL128, PT);
        drive(1, 1'b1, 1'b1, K256, KL256, PT);
        first = -1;
        for (int c = 0; c < 100 && first < 0; c++) begin
            #1;
            if (req0_ready === 1'b1) first = 0;
            else if (req1_ready === 1'b1) first = 1;
            else @(negedge clk);
        end
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post-reset first grant", 256'(first), 256'd0);
        wait_resp(0, c0, seen);
        chk("post-reset resp", 256'(seen), 256'd1);
        chk("post-reset result", 256'(r0_res), 256'(CT128));
        chk("post-reset inits", 256'(init_cnt - i0), 256'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
